// File: rtl/serial_adder_arbiter.sv
// Round-robin arbiter that shares one bit-serial adder among NUM_REQ requesters:
// operands are shifted out LSB-first and the serial sum is reassembled into a tagged response.
module serial_adder_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_en,
    input  logic [NUM_REQ-1:0]              i_req_valid,
    output logic [NUM_REQ-1:0]              o_req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_b,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic [DATA_WIDTH-1:0]           o_rsp_sum,
    output logic                            o_rsp_cout,
    output logic [ID_W-1:0]                 o_rsp_id,
    output logic                            o_add_en,
    output logic                            o_add_valid,
    output logic                            o_add_din_a,
    output logic                            o_add_din_b,
    input  logic                            i_add_ready,
    input  logic                            i_add_valid,
    input  logic                            i_add_sum,
    input  logic                            i_add_cout,
    output logic                            o_add_ready,
    output logic                            o_busy
);
    localparam int unsigned      NREQ      = NUM_REQ;
    localparam int               CNT_W     = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d, id_q, id_d, gnt_idx;
    logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d, a_sel, b_sel;
    logic                   cout_q, cout_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   gnt_found, run, grant, in_xfer, out_xfer, rsp_done, last_beat;
    logic [NUM_REQ-1:0]     req_sh;
    int unsigned            cand;

    // Reset also masks the enable so no handshake or grant can fire while it is asserted.
    assign run       = i_en & ~i_rst;
    assign last_beat = (cnt_q == LAST_BEAT);
    assign grant     = run && (state_q == IDLE) && gnt_found;
    assign in_xfer   = run && (state_q == SEND) && i_add_ready;
    assign out_xfer  = run && (state_q == RECV) && i_add_valid;
    assign rsp_done  = run && (state_q == RESP) && i_rsp_ready;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        req_sh    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            req_sh = i_req_valid >> cand;
            if (!gnt_found && req_sh[0]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(cand);
            end
        end
    end

    assign a_sel = i_req_a[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];
    assign b_sel = i_req_b[32'(gnt_idx) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (grant)                 state_d = SEND;
            SEND: if (in_xfer && last_beat)  state_d = RECV;
            RECV: if (out_xfer && last_beat) state_d = RESP;
            RESP: if (rsp_done)              state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = '0;
        if (grant) o_req_ready = NUM_REQ'(1) << gnt_idx;
        o_add_valid = run && (state_q == SEND);
        o_add_ready = run && (state_q == RECV);
        o_rsp_valid = (state_q == RESP);
        o_busy      = (state_q != IDLE);
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        if (grant) begin
            a_d    = a_sel;
            b_d    = b_sel;
            sum_d  = '0;
            cout_d = 1'b0;
            id_d   = gnt_idx;
            ptr_d  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt_d  = '0;
        end
        if (in_xfer) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
        end
        if (out_xfer) begin
            // Shifting in from the MSB lands beat n at sum[n] after the full word.
            sum_d = {i_add_sum, sum_q[DATA_WIDTH-1:1]};
            cnt_d = last_beat ? '0 : cnt_q + 1'b1;
            if (last_beat) cout_d = i_add_cout;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            id_q   <= '0;
            ptr_q  <= '0;
            cnt_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_add_en    = run;
    assign o_add_din_a = a_q[0];
    assign o_add_din_b = b_q[0];
    assign o_rsp_sum   = sum_q;
    assign o_rsp_cout  = cout_q;
    assign o_rsp_id    = id_q;

endmodule

// File: tb/tb_serial_adder_arbiter.sv
// Bench for serial_adder_arbiter: behavioural bit-serial adder, round-robin reference model
// and a response scoreboard fed at grant time.
module tb_serial_adder_arbiter;
    localparam int DW  = 16;
    localparam int NR  = 4;
    localparam int IDW = 2;

    logic              i_clk = 1'b0;
    logic              i_rst, i_en;
    logic [NR-1:0]     i_req_valid, o_req_ready;
    logic [NR*DW-1:0]  i_req_a, i_req_b;
    logic              o_rsp_valid, i_rsp_ready;
    logic [DW-1:0]     o_rsp_sum;
    logic              o_rsp_cout;
    logic [IDW-1:0]    o_rsp_id;
    logic              o_add_en, o_add_valid, o_add_din_a, o_add_din_b;
    logic              i_add_ready, i_add_valid, i_add_sum, i_add_cout;
    logic              o_add_ready, o_busy;

    always #5 i_clk = ~i_clk;

    serial_adder_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_a(i_req_a), .i_req_b(i_req_b),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_sum(o_rsp_sum), .o_rsp_cout(o_rsp_cout), .o_rsp_id(o_rsp_id),
        .o_add_en(o_add_en), .o_add_valid(o_add_valid),
        .o_add_din_a(o_add_din_a), .o_add_din_b(o_add_din_b),
        .i_add_ready(i_add_ready), .i_add_valid(i_add_valid),
        .i_add_sum(i_add_sum), .i_add_cout(i_add_cout),
        .o_add_ready(o_add_ready), .o_busy(o_busy)
    );

    logic [DW-1:0] req_a [NR];
    logic [DW-1:0] req_b [NR];
    always_comb begin
        for (int k = 0; k < NR; k++) begin
            i_req_a[k*DW +: DW] = req_a[k];
            i_req_b[k*DW +: DW] = req_b[k];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural serial adder ----------------
    logic [1:0] aq[$];
    logic       am_c, am_s, am_cn, am_a, am_b, am_in, am_out;
    int         am_in_beats = 0, am_out_beats = 0, am_out_total = 0;
    bit         add_rdy_rand = 0, add_vld_rand = 0;

    initial begin
        am_c = 1'b0;
        i_add_ready = 1'b1; i_add_valid = 1'b0; i_add_sum = 1'b0; i_add_cout = 1'b0;
        forever begin
            @(posedge i_clk);
            am_in  = o_add_valid && i_add_ready;
            am_out = i_add_valid && o_add_ready;
            am_a   = o_add_din_a;
            am_b   = o_add_din_b;
            if (i_rst) begin
                aq.delete();
                am_c = 1'b0; am_in_beats = 0; am_out_beats = 0;
            end else begin
                if (am_out) begin
                    void'(aq.pop_front());
                    am_out_total++;
                    am_out_beats = (am_out_beats == DW-1) ? 0 : am_out_beats + 1;
                end
                if (am_in) begin
                    am_s  = am_a ^ am_b ^ am_c;
                    am_cn = (am_a & am_b) | (am_c & (am_a ^ am_b));
                    aq.push_back({am_cn, am_s});
                    am_c  = (am_in_beats == DW-1) ? 1'b0 : am_cn;
                    am_in_beats = (am_in_beats == DW-1) ? 0 : am_in_beats + 1;
                end
            end
            #2;
            i_add_ready = add_rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            i_add_valid = (aq.size() > 0) && (add_vld_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (aq.size() > 0) {i_add_cout, i_add_sum} = aq[0];
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct { logic [IDW-1:0] id; logic [DW:0] res; } exp_t;
    exp_t expq[$];
    int   glog[$];
    int   ptr_m = 0;
    bit   busy_m = 0;
    int   last_lat = 0;

    function automatic int pick(input int p, input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[(p + i) % NR]) return (p + i) % NR;
        end
        return -1;
    endfunction

    initial begin
        int   cyc = 0, acc_cyc = 0, g;
        bit   prev_rv = 0;
        logic [NR-1:0] exp_rr;
        exp_t e;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (i_rst) begin
                check("reset_outputs", 32'({o_req_ready, o_rsp_valid, o_rsp_sum, o_rsp_cout, o_rsp_id,
                      o_add_en, o_add_valid, o_add_ready, o_add_din_a, o_add_din_b, o_busy}), 32'd0);
                expq.delete();
                ptr_m = 0; busy_m = 0; prev_rv = 0;
                continue;
            end
            check("busy", 32'(o_busy), 32'(busy_m));
            exp_rr = '0;
            g = -1;
            if (i_en && !busy_m) g = pick(ptr_m, i_req_valid);
            if (g >= 0) exp_rr = NR'(1) << g;
            check("req_ready", 32'(o_req_ready), 32'(exp_rr));
            if (g >= 0) begin
                expq.push_back('{id: IDW'(g), res: 17'(req_a[g]) + 17'(req_b[g])});
                glog.push_back(g);
                ptr_m = (g + 1) % NR;
                busy_m = 1;
                acc_cyc = cyc;
            end
            if (o_rsp_valid && !prev_rv) last_lat = cyc - acc_cyc;
            prev_rv = o_rsp_valid;
            if (o_rsp_valid && i_rsp_ready && i_en) begin
                if (expq.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    check("rsp_sum", 32'(o_rsp_sum), 32'(e.res[DW-1:0]));
                    check("rsp_cout", 32'(o_rsp_cout), 32'(e.res[DW]));
                    check("rsp_id", 32'(o_rsp_id), 32'(e.id));
                end
                busy_m = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit hold_valid = 0, rsp_rand = 0, en_rand = 0;

    task automatic tick();
        logic [NR-1:0] acc;
        @(posedge i_clk);
        acc = o_req_ready;
        #2;
        for (int k = 0; k < NR; k++) begin
            if (acc[k]) begin
                if (hold_valid) begin
                    req_a[k] = DW'($urandom);
                    req_b[k] = DW'($urandom);
                end else begin
                    i_req_valid[k] = 1'b0;
                end
            end
        end
        if (rsp_rand) i_rsp_ready = 1'($urandom_range(0, 1));
        if (en_rand)  i_en = ($urandom_range(0, 9) != 0);
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL timeout_%s: wait expired, required completion", name);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(i_req_valid == '0 && expq.size() == 0 && !busy_m) && n < budget);
        if (n >= budget) timeout_fail(name);
    endtask

    task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_a[k] = a;
        req_b[k] = b;
        i_req_valid[k] = 1'b1;
    endtask

    initial begin
        int base, n, snap;
        for (int k = 0; k < NR; k++) begin
            req_a[k] = '0;
            req_b[k] = '0;
        end
        i_req_valid = '0; i_en = 1'b1; i_rsp_ready = 1'b1; i_rst = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;

        // single requester, baseline latency
        base = glog.size();
        set_req(0, 16'h1234, 16'h4321);
        wait_done("t1", 500);
        check("t1_grant_count", 32'(glog.size() - base), 32'd1);
        check("t1_latency", 32'(last_lat), 32'(2*DW + 1));

        set_req(2, 16'hFFFF, 16'h0001);
        wait_done("t2", 500);

        // reset at SEND beat 5, then ptr must restart at 0
        set_req(1, DW'($urandom), DW'($urandom));
        n = 0;
        while (am_in_beats != 5 && n < 200) begin tick(); n++; end
        if (n >= 200) timeout_fail("beat5");
        i_rst = 1'b1;
        repeat (2) tick();
        i_rst = 1'b0;
        base = glog.size();
        set_req(1, DW'($urandom), DW'($urandom));
        set_req(3, 16'h00FF, 16'h0F0F);
        wait_done("t3", 500);
        check("t3_grants", 32'(glog.size() - base), 32'd2);
        if (glog.size() - base == 2) begin
            check("t3_first_grant", 32'(glog[base]), 32'd1);
            check("t3_second_grant", 32'(glog[base+1]), 32'd3);
        end

        // all four held valid
        base = glog.size();
        hold_valid = 1;
        for (int k = 0; k < NR; k++) set_req(k, DW'($urandom), DW'($urandom));
        n = 0;
        while (glog.size() < base + 5 && n < 1000) begin tick(); n++; end
        if (n >= 1000) timeout_fail("t4");
        hold_valid = 0;
        wait_done("t4_drain", 1000);
        if (glog.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("t4_order%0d", i), 32'(glog[base+i]), 32'(i % NR));
        end

        // response back-pressure
        i_rsp_ready = 1'b0;
        set_req(0, 16'hAAAA, 16'h5555);
        n = 0;
        while (!o_rsp_valid && n < 200) begin tick(); n++; end
        if (n >= 200) timeout_fail("t5_rsp");
        set_req(2, DW'($urandom), DW'($urandom));
        base = glog.size();
        repeat (10) begin
            tick();
            check("t5_hold_valid", 32'(o_rsp_valid), 32'd1);
            check("t5_hold_sum", 32'(o_rsp_sum), 32'hFFFF);
            check("t5_hold_id", 32'(o_rsp_id), 32'd0);
        end
        check("t5_no_grant", 32'(glog.size() - base), 32'd0);
        i_rsp_ready = 1'b1;
        wait_done("t5", 500);

        // i_add_ready toggling during SEND
        add_rdy_rand = 1;
        set_req(1, DW'($urandom), DW'($urandom));
        set_req(3, DW'($urandom), DW'($urandom));
        wait_done("t6", 1000);
        add_rdy_rand = 0;

        // enable gap in the middle of RECV
        set_req(0, DW'($urandom), DW'($urandom));
        n = 0;
        while (am_out_beats != 8 && n < 200) begin tick(); n++; end
        if (n >= 200) timeout_fail("t7_recv");
        snap = am_out_total;
        i_en = 1'b0;
        repeat (5) tick();
        check("t7_no_beats", 32'(am_out_total - snap), 32'd0);
        i_en = 1'b1;
        wait_done("t7", 500);
        check("t7_latency", 32'(last_lat), 32'(2*DW + 1 + 5));

        // randomized traffic with stalls everywhere
        add_rdy_rand = 1; add_vld_rand = 1; rsp_rand = 1; en_rand = 1;
        repeat (1500) begin
            tick();
            for (int k = 0; k < NR; k++) begin
                if (!i_req_valid[k] && $urandom_range(0, 7) == 0) set_req(k, DW'($urandom), DW'($urandom));
            end
        end
        add_rdy_rand = 0; add_vld_rand = 0; rsp_rand = 0; en_rand = 0;
        i_en = 1'b1; i_rsp_ready = 1'b1;
        wait_done("t8", 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule

// File: doc/serial_adder_arbiter.md
# serial_adder_arbiter

Round-robin arbiter and sequencer that shares one bit-serial adder (`top_level`) among `NUM_REQ` parallel-word requesters. It grants one requester at a time and captures its operand words. It serializes the operands LSB-first into the adder, deserializes the serial sum and carry-out, and returns a tagged parallel result. It sits between the requester fabric and the single adder instance and owns that adder's input and output handshakes.

## Interface
Parameters:
- `DATA_WIDTH`, 16, operand/sum width; must match the adder instance.
- `NUM_REQ`, 4, number of requesters, ≥2.
- `ID_W`, `$clog2(NUM_REQ)` (localparam), width of the requester tag.

Ports:
- `i_clk` in 1: single clock; all logic is on the rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_en` in 1: global enable; when low, all state holds.
- `i_req_valid` in NUM_REQ: per-requester request valid.
- `o_req_ready` in/out: out NUM_REQ; one-cycle accept pulse to the granted requester.
- `i_req_a`, `i_req_b` in NUM_REQ*DATA_WIDTH: flattened operands; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `o_rsp_valid` out 1, `i_rsp_ready` in 1: response handshake.
- `o_rsp_sum` out DATA_WIDTH, `o_rsp_cout` out 1, `o_rsp_id` out ID_W: result fields and the tag of the requester that was served.
- `o_add_en`, `o_add_valid`, `o_add_din_a`, `o_add_din_b` out 1: drive the adder's `i_en`, `i_valid`, `i_din_a` and `i_din_b`.
- `i_add_ready` in 1: the adder's `o_ready`.
- `i_add_valid`, `i_add_sum`, `i_add_cout` in 1: the adder's `o_valid`, `o_sum` and `o_cout`.
- `o_add_ready` out 1: drives the adder's `i_ready`.
- `o_busy` out 1: high whenever the FSM is not in IDLE.

## Operation
Adder contract:
- An input beat transfers on each cycle where `o_add_valid && i_add_ready`.
- An output beat transfers on each cycle where `i_add_valid && o_add_ready`.
- Both directions run LSB first, DATA_WIDTH beats per word.
- `i_add_cout` is sampled on the last output beat.

FSM states: IDLE, SEND, RECV, RESP.
- **IDLE:** if any `i_req_valid` is set and `i_en` is high, grant round-robin.
  - Search from pointer `ptr` upward with wrap-around; the first valid index g wins.
  - Pulse `o_req_ready[g]` for that cycle.
  - Capture `i_req_a[g]` and `i_req_b[g]` into shift registers and g into the id register.
  - Set `ptr` to g+1 mod NUM_REQ, clear the bit counter, and go to SEND.
- **SEND:**
  - `o_add_valid` is 1; `o_add_din_a` and `o_add_din_b` are the LSBs of the shift registers.
  - On each transfer, shift right and increment the counter.
  - When the transfer of beat DATA_WIDTH-1 occurs, go to RECV.
  - If `i_add_ready` is low, the current bit holds and nothing advances.
- **RECV:**
  - `o_add_ready` is 1.
  - On each transfer, write `i_add_sum` into `sum[cnt]` and increment the counter.
  - On the last beat, capture `i_add_cout` and go to RESP.
  - `i_add_valid` seen outside RECV is ignored, because `o_add_ready` is 0 there.
- **RESP:**
  - `o_rsp_valid` is 1, and the sum, cout and id are held stable.
  - When `i_rsp_ready` is high, go to IDLE.
  - Only one transaction is ever outstanding, so no grant is made outside IDLE.

Enable and outputs:
- While `i_en` is low:
  - `o_add_valid`, `o_add_ready` and `o_req_ready` are forced to 0.
  - The counter, shift registers, `ptr` and the FSM all hold.
  - `o_rsp_valid` holds its value, but the response is not consumed.
- `o_add_en` equals `i_en`.
- `o_busy` is 1 whenever the state is not IDLE.

Arithmetic: none is performed locally. The counter is `$clog2(DATA_WIDTH)+1` bits wide and never wraps within a word.

## Timing
Reset (`i_rst` high):
- All outputs go to 0 immediately (asynchronous); state becomes IDLE, `ptr` = 0, and all registers are cleared.
- A reset mid-transaction drops the in-flight request; no response is issued.
- The arbiter does not reset the adder; the system reset covers it.

Latency:
- Let the accept edge be cycle T.
- With `i_add_ready` held high, SEND occupies cycles T+1 to T+DATA_WIDTH.
- RECV begins at T+DATA_WIDTH+1 and lasts DATA_WIDTH cycles plus the adder's own latency before it asserts `i_add_valid`.
- `o_rsp_valid` rises the cycle after the last RECV beat.
- The earliest next grant is the cycle after the response is accepted.
- Each stall cycle (`i_en` low, or `i_add_ready`/`i_add_valid` low) adds exactly one cycle of latency.

Other rules:
- A simultaneous request from the requester just served loses to any other valid requester, because `ptr` has already moved past it.
- `o_req_ready` is never high for more than one bit at a time, nor for more than one cycle per grant.

## Test plan
- Only req0 valid, A=0x1234, B=0x4321: `o_req_ready[0]` pulses exactly once; the response is sum=0x5555, cout=0, id=0.
- Req2 with A=0xFFFF, B=0x0001: the response is sum=0x0000, cout=1, id=2.
- All four requesters held valid, each with distinct operands: grants occur in the order 0,1,2,3,0, and each id and sum matches its own operands.
- `i_rsp_ready` held low for 10 cycles in RESP: the response stays stable and no `o_req_ready` pulses occur. Separately, toggling `i_add_ready` during SEND leaves the adder input bit sequence intact and the result correct.
- `i_rst` pulsed at SEND beat 5:
  - All outputs are 0 during reset and `ptr` is 0 afterwards.
  - No response is issued for the dropped request.
  - A following req3 with A=0x00FF, B=0x0F0F completes with sum=0x100E, cout=0.
- `i_en` low for 5 cycles in mid-RECV: no beats transfer during the gap, the result is correct, and latency increases by exactly 5 cycles.
